// File: rtl/fir_interp2.sv
// Interpolate-by-2 polyphase pulse-shaping FIR (8 taps, 2x4 branches).
// One input in, two filtered outputs out (phase 0 then phase 1).
module fir_interp2 #(
  parameter int COEF_W = 8,
  parameter int C0 = -3,
  parameter int C1 = 5,
  parameter int C2 = 20,
  parameter int C3 = 32,
  parameter int C4 = 32,
  parameter int C5 = 20,
  parameter int C6 = 5,
  parameter int C7 = -3,
  parameter int SHIFT = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic signed [15:0] in_data,
  input  logic               in_valid,
  output logic               in_ready,
  output logic signed [15:0] out_data,
  output logic               out_valid,
  input  logic               out_ready
);

  localparam int PROD_W = 16 + COEF_W;
  localparam int ACC_W  = 18 + COEF_W;

  typedef logic signed [COEF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]  acc_t;
  typedef logic signed [PROD_W-1:0] prod_t;

  localparam coef_t H0 = coef_t'(C0);
  localparam coef_t H1 = coef_t'(C1);
  localparam coef_t H2 = coef_t'(C2);
  localparam coef_t H3 = coef_t'(C3);
  localparam coef_t H4 = coef_t'(C4);
  localparam coef_t H5 = coef_t'(C5);
  localparam coef_t H6 = coef_t'(C6);
  localparam coef_t H7 = coef_t'(C7);

  localparam acc_t SAT_HI = acc_t'(32767);
  localparam acc_t SAT_LO = acc_t'(-32768);

  typedef enum logic [1:0] {
    EMPTY,
    PH0,
    PH1
  } state_t;

  state_t state, state_d;

  logic signed [15:0] x0, x1, x2, x3;
  logic signed [15:0] out_d;
  logic               shift_en;
  logic               in_xfer;
  logic               out_xfer;
  acc_t               y0_new;
  acc_t               y1_cur;

  function automatic acc_t mac4(
    input logic signed [15:0] a,
    input logic signed [15:0] b,
    input logic signed [15:0] c,
    input logic signed [15:0] d,
    input coef_t              ha,
    input coef_t              hb,
    input coef_t              hc,
    input coef_t              hd
  );
    prod_t pa, pb, pc, pd;
    pa = prod_t'(a) * prod_t'(ha);
    pb = prod_t'(b) * prod_t'(hb);
    pc = prod_t'(c) * prod_t'(hc);
    pd = prod_t'(d) * prod_t'(hd);
    return acc_t'(pa) + acc_t'(pb)
         + acc_t'(pc) + acc_t'(pd);
  endfunction

  // floor shift, then clamp into the 16-bit range
  function automatic logic signed [15:0] sat16(
    input acc_t acc
  );
    acc_t s;
    s = acc >>> SHIFT;
    if (s > SAT_HI)
      return 16'sh7fff;
    else if (s < SAT_LO)
      return 16'sh8000;
    else
      return 16'(s);
  endfunction

  // phase 0 sees the line as it will be after the incoming sample
  assign y0_new = mac4(in_data, x0, x1, x2,
                       H0, H2, H4, H6);
  assign y1_cur = mac4(x0, x1, x2, x3,
                       H1, H3, H5, H7);

  assign out_valid = enable && (state != EMPTY);
  assign in_ready  = rst_n && enable
                  && ((state == EMPTY)
                   || ((state == PH1) && out_ready));
  assign in_xfer   = in_valid && in_ready;
  assign out_xfer  = out_valid && out_ready;

  // next-state, delay-line shift and output data selection
  always_comb begin
    state_d  = state;
    out_d    = out_data;
    shift_en = 1'b0;
    unique case (state)
      EMPTY: begin
        if (in_xfer) begin
          shift_en = 1'b1;
          out_d    = sat16(y0_new);
          state_d  = PH0;
        end
      end
      PH0: begin
        if (out_xfer) begin
          out_d   = sat16(y1_cur);
          state_d = PH1;
        end
      end
      PH1: begin
        if (out_xfer) begin
          if (in_xfer) begin
            shift_en = 1'b1;
            out_d    = sat16(y0_new);
            state_d  = PH0;
          end else begin
            state_d = EMPTY;
          end
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  // phase state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      state <= EMPTY;
    else
      state <= state_d;
  end

  // shared 4-deep input delay line
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x0 <= '0;
      x1 <= '0;
      x2 <= '0;
      x3 <= '0;
    end else if (shift_en) begin
      x0 <= in_data;
      x1 <= x0;
      x2 <= x1;
      x3 <= x2;
    end
  end

  // registered output sample
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      out_data <= '0;
    else
      out_data <= out_d;
  end

endmodule

// File: tb/tb_fir_interp2.sv
// Scoreboard bench for fir_interp2: default build and a SHIFT=5 build
// share stimulus; a tap-sum reference model predicts both.
module tb_fir_interp2;

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               enable = 1'b1;
  logic signed [15:0] in_data = '0;
  logic               in_valid = 1'b0;
  logic               out_ready = 1'b1;

  logic               a_in_ready, b_in_ready;
  logic               a_out_valid, b_out_valid;
  logic signed [15:0] a_out_data, b_out_data;

  int checks = 0;
  int failures = 0;

  int h [8] = '{-3, 5, 20, 32, 32, 20, 5, -3};
  int sh [2] = '{6, 5};
  int hist [2][4];
  int q [2][$];
  int last [2];
  int alog [$];
  int blog [$];
  bit rand_mode = 1'b0;

  logic               ir [2];
  logic               ov [2];
  logic signed [15:0] od [2];

  assign ir[0] = a_in_ready;
  assign ir[1] = b_in_ready;
  assign ov[0] = a_out_valid;
  assign ov[1] = b_out_valid;
  assign od[0] = a_out_data;
  assign od[1] = b_out_data;

  always #5 clk = ~clk;

  fir_interp2 u_a (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (a_in_ready),
    .out_data  (a_out_data),
    .out_valid (a_out_valid),
    .out_ready (out_ready)
  );

  fir_interp2 #(.SHIFT(5)) u_b (
    .clk       (clk),
    .rst_n     (rst_n),
    .enable    (enable),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (b_in_ready),
    .out_data  (b_out_data),
    .out_valid (b_out_valid),
    .out_ready (out_ready)
  );

  task automatic chk(input string nm, input int d,
                     input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL dut%0d %s actual=%0d required=%0d",
               d, nm, act, exp);
    end
  endtask

  // output k of phase p = sum_j h[2j+p] * x[n-j], floor-shifted, clamped
  function automatic int model_y(input int d, input int ph);
    longint acc = 0;
    for (int k = 0; k < 4; k++)
      acc += longint'(h[2*k+ph]) * longint'(hist[d][k]);
    acc = acc >>> sh[d];
    if (acc > 32767) acc = 32767;
    if (acc < -32768) acc = -32768;
    return int'(acc);
  endfunction

  task automatic accept(input int d);
    for (int k = 3; k > 0; k--)
      hist[d][k] = hist[d][k-1];
    hist[d][0] = int'(in_data);
    q[d].push_back(model_y(d, 0));
    q[d].push_back(model_y(d, 1));
  endtask

  // stimulus side: record accepted samples into the model
  always begin
    @(negedge clk);
    #1;
    if (in_valid && a_in_ready) accept(0);
    if (in_valid && b_in_ready) accept(1);
  end

  // monitor: handshake and data checked against model every cycle
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      int  n;
      bit  e_ir, e_ov;
      int  e_od;
      n    = q[d].size();
      e_ir = rst_n && enable
          && (n == 0 || (n == 1 && out_ready));
      e_ov = rst_n && enable && (n > 0);
      e_od = (n > 0) ? q[d][0] : last[d];
      chk("in_ready", d, longint'(ir[d]), longint'(e_ir));
      chk("out_valid", d, longint'(ov[d]), longint'(e_ov));
      chk("out_data", d, longint'(od[d]), longint'(e_od));
      if (e_ov && out_ready) begin
        last[d] = q[d].pop_front();
        if (d == 0) alog.push_back(last[d]);
        else blog.push_back(last[d]);
      end
    end
  end

  // random handshake pressure when enabled
  always @(posedge clk) begin
    #1;
    if (rand_mode) begin
      out_ready = ($urandom_range(0, 3) != 0);
      enable    = ($urandom_range(0, 7) != 0);
    end
  end

  task automatic model_clear();
    for (int d = 0; d < 2; d++) begin
      q[d].delete();
      last[d] = 0;
      for (int k = 0; k < 4; k++) hist[d][k] = 0;
    end
  endtask

  task automatic do_reset(input int n);
    rst_n    = 1'b0;
    in_valid = 1'b0;
    model_clear();
    repeat (n) begin
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input logic signed [15:0] v);
    bit ok = 1'b0;
    in_data  = v;
    in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (a_in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 0, 0, 1);
      in_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic check_impulse();
    int exp [10] = '{-3, 5, 20, 32, 32, 20, 5, -3, 0, 0};
    chk("impulse_count", 0, alog.size(), 10);
    for (int i = 0; i < 10 && i < alog.size(); i++)
      chk("impulse_tap", 0, alog[i], exp[i]);
  endtask

  initial begin
    model_clear();
    in_valid = 1'b1;
    in_data  = 16'sd77;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    rst_n    = 1'b1;
    in_valid = 1'b0;
    idle(2);

    // impulse
    alog.delete();
    send(16'sd64);
    repeat (4) send(16'sd0);
    idle(6);
    check_impulse();

    // DC level
    alog.delete();
    repeat (8) send(16'sd1000);
    idle(4);
    for (int i = 6; i < 16 && i < alog.size(); i++)
      chk("dc_level", 0, alog[i], 843);

    // saturation on the SHIFT=5 build
    blog.delete();
    repeat (8) send(16'sd32767);
    repeat (8) send(-16'sd32768);
    idle(4);
    chk("sat_count", 1, blog.size(), 32);
    for (int i = 6; i < 16 && i < blog.size(); i++)
      chk("sat_hi", 1, blog[i], 32767);
    for (int i = 22; i < 32 && i < blog.size(); i++)
      chk("sat_lo", 1, blog[i], -32768);

    // backpressure held in PH0
    out_ready = 1'b0;
    send(16'sd1234);
    idle(5);
    out_ready = 1'b1;
    send(-16'sd999);
    idle(4);

    // enable dropped in PH1
    send(16'sd2500);
    idle(1);
    enable = 1'b0;
    idle(3);
    enable = 1'b1;
    idle(4);

    // reset in PH0 after an impulse
    send(16'sd64);
    do_reset(2);
    idle(1);
    alog.delete();
    send(16'sd64);
    repeat (4) send(16'sd0);
    idle(6);
    check_impulse();

    // randomized traffic
    rand_mode = 1'b1;
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 7))
        0:       send(16'sd32767);
        1:       send(-16'sd32768);
        default: send(16'($urandom));
      endcase
      if ($urandom_range(0, 3) == 0)
        idle($urandom_range(1, 4));
    end
    rand_mode = 1'b0;
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    enable    = 1'b1;
    idle(8);
    chk("drained", 0, q[0].size(), 0);
    chk("drained", 1, q[1].size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
